present_inv_round_engine: RTL

Iterative PRESENT block-decryption datapath: accepts one 64-bit ciphertext block and applies the final-key whitening inverse plus 31 inverse rounds (inverse permutation, inverse substitution, round-key XOR), one round per clock. It is the decrypt-side counterpart of the encryption substitution/permutation round path. It sits between the block input buffer and the plaintext output stage. Round keys come from the external round-key store by index.

---
 rtl/present_pkg.sv | 29 ++
 rtl/present_inv_sbox_layer.sv | 13 +
 rtl/present_inv_round_engine.sv | 92 +++++++++
 3 files changed

// File: rtl/present_pkg.sv
// Shared constants and helpers for the PRESENT inverse round path:
// round count, inverse S-box table, inverse bit permutation and FSM states.
package present_pkg;

  localparam int ROUNDS = 31;

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Output bit i takes input bit (16*i) mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] inv_player(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[6'(i)] = x[6'((16 * i) % 63)];
    end
    y[63] = x[63];
    return y;
  endfunction

endpackage

// File: rtl/present_inv_sbox_layer.sv
// Combinational inverse substitution layer: 16 parallel 4-bit INV_SBOX lookups.
module present_inv_sbox_layer
  import present_pkg::*;
(
  input  logic [63:0] data,
  output logic [63:0] result
);

  for (genvar gi = 0; gi < 16; gi++) begin : g_nibble
    assign result[4*gi +: 4] = INV_SBOX[data[4*gi +: 4]];
  end

endmodule

// File: rtl/present_inv_round_engine.sv
// Iterative PRESENT decryption: K32 whitening at accept, then one inverse round per clock.
// Optional build macro PRESENT_INV_ZEROIZE_EN clears the plaintext on the output handshake.
module present_inv_round_engine
  import present_pkg::*;
#(
  parameter int ROUNDS = present_pkg::ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic [4:0]  rk_idx,
  input  logic [63:0] rk,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  state_e      fsm_reg, fsm_next;
  logic [4:0]  rnd_reg, rnd_next;
  logic [63:0] state_reg, state_next;
  logic [63:0] perm;
  logic [63:0] subst;

  assign perm = inv_player(state_reg);

  present_inv_sbox_layer u_inv_sbox (
    .data   (perm),
    .result (subst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg   <= IDLE;
      rnd_reg   <= '0;
      state_reg <= '0;
    end else begin
      fsm_reg   <= fsm_next;
      rnd_reg   <= rnd_next;
      state_reg <= state_next;
    end
  end

  // rk_idx is derived from registered state only, so the key store sees a stable index.
  always_comb begin
    fsm_next   = fsm_reg;
    rnd_next   = rnd_reg;
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rk_idx     = 5'(ROUNDS);
    case (fsm_reg)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          state_next = in_data ^ rk;
          rnd_next   = 5'(ROUNDS - 1);
          fsm_next   = ROUND;
        end
      end
      ROUND: begin
        rk_idx     = rnd_reg;
        state_next = subst ^ rk;
        if (rnd_reg == '0) begin
          fsm_next = DONE;
        end else begin
          rnd_next = rnd_reg - 5'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_next = IDLE;
`ifdef PRESENT_INV_ZEROIZE_EN
          state_next = '0;
`endif
        end
      end
      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

`ifdef PRESENT_INV_ZEROIZE_EN
  assign out_data = (fsm_reg == DONE) ? state_reg : 64'd0;
`else
  assign out_data = state_reg;
`endif

endmodule
